// File: rtl/snn_spike_decoder.sv
// Rate decoder for SNN output spikes: counts spikes per neuron over a WINDOW-cycle
// window and reports the argmax class. Optional counts_out port: SPKDEC_COUNTS_OUT_EN.
module snn_spike_decoder #(
  parameter int N_OUT  = 2,
  parameter int WINDOW = 64,
  parameter int CNT_W  = 8,
  localparam int CLS_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_OUT-1:0]       spikes_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic [CLS_W-1:0]       result_class,
  output logic                   result_tie,
  output logic                   result_none,
`ifdef SPKDEC_COUNTS_OUT_EN
  output logic [N_OUT*CNT_W-1:0] counts_out,
`endif
  output logic [1:0]             state_dbg
);

  localparam int WIN_W = $clog2(WINDOW + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Handshake: result_valid rises one cycle after entering DONE and holds with all
  // result fields frozen; an edge with result_valid=1 and result_ack=1 retires it.
  logic [1:0]       state;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] cnt      [N_OUT];
  logic [CNT_W-1:0] cnt_next [N_OUT];

  logic [CNT_W-1:0] best;
  logic [CLS_W-1:0] best_idx;
  logic             best_tie;
  logic             best_none;

  assign state_dbg = state;

  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      cnt_next[i] = cnt[i];
      if (spikes_in[i] && (cnt[i] != {CNT_W{1'b1}}))
        cnt_next[i] = cnt[i] + CNT_W'(1);
    end
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    best     = cnt[0];
    best_idx = '0;
    best_tie = 1'b0;
    for (int i = 1; i < N_OUT; i++) begin
      if (cnt[i] > best) begin
        best     = cnt[i];
        best_idx = CLS_W'(i);
        best_tie = 1'b0;
      end else if (cnt[i] == best) begin
        best_tie = 1'b1;
      end
    end
    best_none = (best == '0);
    if (best_none)
      best_tie = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_tie   <= 1'b0;
      result_none  <= 1'b0;
      win_cnt      <= '0;
      for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
`ifdef SPKDEC_COUNTS_OUT_EN
      counts_out   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_COUNT;
            busy    <= 1'b1;
            win_cnt <= WIN_W'(WINDOW);
            for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
          end
        end
        S_COUNT: begin
          for (int i = 0; i < N_OUT; i++) cnt[i] <= cnt_next[i];
          win_cnt <= win_cnt - WIN_W'(1);
          if (win_cnt == WIN_W'(1))
            state <= S_DECIDE;
        end
        S_DECIDE: begin
          state        <= S_DONE;
          busy         <= 1'b0;
          result_class <= best_idx;
          result_tie   <= best_tie;
          result_none  <= best_none;
`ifdef SPKDEC_COUNTS_OUT_EN
          for (int i = 0; i < N_OUT; i++) counts_out[i*CNT_W +: CNT_W] <= cnt[i];
`endif
        end
        default: begin
          if (!result_valid) begin
            result_valid <= 1'b1;
          end else if (result_ack) begin
            result_valid <= 1'b0;
            if (start) begin
              state   <= S_COUNT;
              busy    <= 1'b1;
              win_cnt <= WIN_W'(WINDOW);
              for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
            end else begin
              state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snn_spike_decoder.sv
// Bench for snn_spike_decoder: directed windows on a CNT_W=8 and a CNT_W=3 instance
// sharing stimulus; expected results are queued at start and checked on result_valid.
module tb_snn_spike_decoder;

  localparam int N_OUT  = 2;
  localparam int WINDOW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [1:0] spikes_in = '0;
  logic       start = 1'b0;
  logic       result_ack = 1'b0;

  logic       busy_a, valid_a, class_a, tie_a, none_a;
  logic [1:0] state_a;
  logic       busy_b, valid_b, class_b, tie_b, none_b;
  logic [1:0] state_b;
`ifdef SPKDEC_COUNTS_OUT_EN
  logic [15:0] counts_a;
  logic [5:0]  counts_b;
`endif

  snn_spike_decoder #(.N_OUT(N_OUT), .WINDOW(WINDOW), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .spikes_in(spikes_in), .start(start),
    .busy(busy_a), .result_valid(valid_a), .result_ack(result_ack),
    .result_class(class_a), .result_tie(tie_a), .result_none(none_a),
`ifdef SPKDEC_COUNTS_OUT_EN
    .counts_out(counts_a),
`endif
    .state_dbg(state_a)
  );

  snn_spike_decoder #(.N_OUT(N_OUT), .WINDOW(WINDOW), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .spikes_in(spikes_in), .start(start),
    .busy(busy_b), .result_valid(valid_b), .result_ack(result_ack),
    .result_class(class_b), .result_tie(tie_b), .result_none(none_b),
`ifdef SPKDEC_COUNTS_OUT_EN
    .counts_out(counts_b),
`endif
    .state_dbg(state_b)
  );

  // Entry layout: {count1, count0, none, tie, class}
  logic [18:0] exp_q[$];
  logic [8:0]  exp_sat_q[$];
  logic [18:0] e_a;
  logic [8:0]  e_b;
  logic        pv_a = 1'b0;
  logic        pv_b = 1'b0;

  int checks = 0;
  int fails  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Scoreboard monitors: compare on each rising result_valid.
  always @(negedge clk) begin
    if (valid_a && !pv_a) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_a", 32'd1, 32'd0);
      end else begin
        e_a = exp_q.pop_front();
        check("class_a", {31'd0, class_a}, {31'd0, e_a[0]});
        check("tie_a",   {31'd0, tie_a},   {31'd0, e_a[1]});
        check("none_a",  {31'd0, none_a},  {31'd0, e_a[2]});
`ifdef SPKDEC_COUNTS_OUT_EN
        check("counts_a", {16'd0, counts_a}, {16'd0, e_a[18:3]});
`endif
      end
    end
    pv_a = valid_a;
  end

  always @(negedge clk) begin
    if (valid_b && !pv_b) begin
      if (exp_sat_q.size() == 0) begin
        check("unexpected_result_b", 32'd1, 32'd0);
      end else begin
        e_b = exp_sat_q.pop_front();
        check("class_b", {31'd0, class_b}, {31'd0, e_b[0]});
        check("tie_b",   {31'd0, tie_b},   {31'd0, e_b[1]});
        check("none_b",  {31'd0, none_b},  {31'd0, e_b[2]});
`ifdef SPKDEC_COUNTS_OUT_EN
        check("counts_b", {26'd0, counts_b}, {26'd0, e_b[8:3]});
`endif
      end
    end
    pv_b = valid_b;
  end

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  {31'd0, busy_a},  32'd0);
    check({tag, "_valid"}, {31'd0, valid_a}, 32'd0);
    check({tag, "_state"}, {30'd0, state_a}, 32'd0);
    check({tag, "_valid_sat"}, {31'd0, valid_b}, 32'd0);
  endtask

  // pat holds sample k (edge E+1+k) at pat[2k+:2].
  task automatic run_window(input logic [15:0] pat,
                            input logic [7:0] c1, input logic [7:0] c0,
                            input logic [2:0] s1, input logic [2:0] s0,
                            input logic cls, input logic tie, input logic none,
                            input bit b2b, input bit noisy, input int hold, input bit chain);
    int n;
    exp_q.push_back({c1, c0, none, tie, cls});
    exp_sat_q.push_back({s1, s0, none, tie, cls});
    @(negedge clk);
    start = 1'b1;
    result_ack = b2b;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) check("busy_after_start", {31'd0, busy_a}, 32'd1);
      start = noisy && (k == 2 || k == 5);
      result_ack = noisy && (k == 4);
      spikes_in = pat[2*k +: 2];
    end
    @(negedge clk);
    spikes_in = 2'b00;
    start = 1'b0;
    result_ack = 1'b0;
    n = 8;
    while (!valid_a && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", n, 32'd10);
    check("busy_in_done", {31'd0, busy_a}, 32'd0);
    repeat (hold) @(negedge clk);
    check("held_valid", {31'd0, valid_a}, 32'd1);
    check("held_class", {31'd0, class_a}, {31'd0, cls});
    check("held_none",  {31'd0, none_a},  {31'd0, none});
    if (!chain) begin
      result_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      result_ack = 1'b0;
      check_idle("after_ack");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("por");
    check("por_class", {31'd0, class_a}, 32'd0);

    // Reset in the middle of a window
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    spikes_in = 2'b11;
    repeat (3) @(negedge clk);
    check("mid_count_state", {30'd0, state_a}, 32'd1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    spikes_in = 2'b00;
    check_idle("mid_reset");
    check("mid_reset_class", {31'd0, class_a}, 32'd0);
    check("mid_reset_tie",   {31'd0, tie_a},   32'd0);
    check("mid_reset_none",  {31'd0, none_a},  32'd0);
`ifdef SPKDEC_COUNTS_OUT_EN
    check("mid_reset_counts", {16'd0, counts_a}, 32'd0);
`endif

    // Neuron 1 fires every cycle (saturates at 7 on the narrow instance)
    run_window(16'hAAAA, 8'd8, 8'd0, 3'd7, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0, 2, 0);
    // Both neurons fire on 3 samples: tie resolved to class 0
    run_window(16'h330C, 8'd3, 8'd3, 3'd3, 3'd3, 1'b0, 1'b1, 1'b0, 0, 0, 1, 0);
    // Silent window, result held 5 cycles before ack
    run_window(16'h0000, 8'd0, 8'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 0, 0, 5, 0);
    // Neuron 0 every cycle; chained into a back-to-back window
    run_window(16'h5555, 8'd0, 8'd8, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1);
    // ack+start together, with stray start/ack pulses during COUNT
    run_window(16'h22E9, 8'd5, 8'd2, 3'd5, 3'd2, 1'b1, 1'b0, 1'b0, 1, 1, 1, 0);

    repeat (3) @(negedge clk);
    check("queues_drained", exp_q.size() + exp_sat_q.size(), 32'd0);
    check_idle("final");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
